id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width of PC, operand and immediate fields.
REQ-002 Parameter CNT_W, 16, width of stall and flush event counters.
REQ-003 clk  in  1  single clock for all state, rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ID_rs1, ID_rs2, ID_rd  in  5 each  register indices decoded in ID.
REQ-006 ID_rs1_used, ID_rs2_used  in  1 each  instruction actually reads rs1/rs2.
REQ-007 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Branch  in  1 each  decoded controls.
REQ-008 ID_ALUOp  in  4  ALU operation code.
REQ-009 ID_pc, ID_rdata1, ID_rdata2, ID_imm  in  XLEN each  PC, register-file read data, immediate.
REQ-010 EX_flush  in  1  taken branch/jump resolved in EX; kill younger instructions.
REQ-011 MEM_hold  in  1  downstream memory not ready; freeze whole front end.
REQ-012 ID_EX_* outputs  out  same widths as REQ-005..REQ-009 (no *_used)  registered ID/EX contents; ID_EX_rs1/rs2/rd feed the forwarding unit.
REQ-013 PC_Write, IF_ID_Write  out  1 each  enable for PC and IF/ID registers.
REQ-014 IF_ID_Flush  out  1  clear IF/ID register at next edge.
REQ-015 state  out  2  current FSM state (debug).
REQ-016 stall_count, flush_count  out  CNT_W each  event counters.

Function
REQ-017 Load-use hazard (combinational) SHALL be: ID_EX_MemRead && ID_EX_rd!=0 && ((ID_rs1_used && ID_rs1==ID_EX_rd) || (ID_rs2_used && ID_rs2==ID_EX_rd)).
REQ-018 Priority each cycle SHALL be EX_flush > MEM_hold > load-use > normal.
REQ-019 Normal: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0; at edge all ID_EX_* load ID_* values.
REQ-020 Load-use: PC_Write=0, IF_ID_Write=0 same cycle; at edge ID_EX becomes a bubble (all 1-bit controls 0, ALUOp 0, rd 0; rs1/rs2/data fields don't-care but SHALL be 0).
REQ-021 Stall SHALL last exactly one cycle per load-use, since the bubble clears ID_EX_MemRead.
REQ-022 MEM_hold: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0; ID_EX SHALL hold its value unchanged; load-use masked.
REQ-023 EX_flush: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1; at edge ID_EX becomes a bubble; overrides simultaneous MEM_hold and load-use.
REQ-024 FSM states RUN=0, STALL=1, HOLD=2, FLUSH=3; state at edge SHALL become FLUSH if EX_flush, else HOLD if MEM_hold, else STALL if load-use, else RUN.
REQ-025 stall_count SHALL increment on each edge where load-use applied (REQ-020); flush_count on each edge where EX_flush applied; both saturate at all-ones, no wrap.
REQ-026 Hold cycles SHALL not increment either counter.
REQ-027 Back-to-back load-use on consecutive instructions SHALL produce one stall per hazard, never two for one hazard.

Reset
REQ-028 rst asserted SHALL asynchronously force ID_EX to bubble (REQ-020 values), ID_EX_pc 0, state RUN, both counters 0.
REQ-029 PC_Write, IF_ID_Write SHALL read 1 and IF_ID_Flush 0 while in reset; first post-reset edge behaves as normal.
REQ-030 Reset mid-stall or mid-hold SHALL discard the pending instruction in ID_EX.

Structure
REQ-031 State encodings and bubble-control constants SHALL live in the shared pipeline package.
REQ-032 One sub-module SHALL be natural: hazard_detect (combinational REQ-017/REQ-018 decode); register and counters stay in id_ex_stage.

Verification
REQ-033 lw x5 in ID_EX (MemRead=1, rd=5), ID add with rs1=5 used -> PC_Write=0, IF_ID_Write=0; next edge ID_EX_RegWrite=0, rd=0, state=STALL, stall_count=1.
REQ-034 Same, but rs1_used=0 and rs1=5 -> no stall, ID_EX loads add, state=RUN.
REQ-035 ID_EX_rd=0 with MemRead=1, ID rs2=0 used -> no stall.
REQ-036 EX_flush=1 with MEM_hold=1 and load-use true -> IF_ID_Flush=1, ID_EX bubble, flush_count=1, stall_count unchanged, state=FLUSH.
REQ-037 MEM_hold for 3 cycles -> ID_EX unchanged all 3 edges, PC_Write=0, counters unchanged, state=HOLD.
REQ-038 Force stall_count to all-ones via 2^CNT_W-1 hazards (CNT_W=4 build) -> further hazard keeps 15; rst mid-stall -> outputs at REQ-028 values before next clk edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the ID/EX stage: FSM encodings, control bundle, bubble constants.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int REG_IDX_W = 5;
    localparam int ALUOP_W   = 4;

    // Stage action chosen each cycle; also the FSM state it leaves behind.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Decoded control bundle carried from ID into EX.
    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A bubble is a no-op: no writeback, no memory access, ALU op 0, rd x0.
    localparam ctrl_t                 CTRL_BUBBLE = '0;
    localparam logic [REG_IDX_W-1:0]  BUBBLE_REG  = '0;

    // True when a source operand that is actually read matches the load destination.
    function automatic logic src_hits(input logic                 used,
                                      input logic [REG_IDX_W-1:0] src,
                                      input logic [REG_IDX_W-1:0] dst);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Hazard decode: picks the stage action (flush > hold > load-use > run) and front-end enables.
// Latency: purely combinational, same cycle.
// Backpressure: deasserts PC/IF-ID write enables on hold and load-use; forces them high in reset.
//
// Ports:
//   i_rst                 stage reset (enables read as "run" while asserted)
//   i_rs1/i_rs2(_used)    ID source indices and whether the instruction reads them
//   i_ex_mem_read/i_ex_rd load-ness and destination of the instruction now in ID/EX
//   i_ex_flush/i_mem_hold redirect from EX, downstream memory not ready
//   o_action              action for the coming edge (also next FSM state)
//   o_pc_write/o_if_id_write/o_if_id_flush  front-end controls
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                 i_rst,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    input  logic                 i_rs1_used,
    input  logic                 i_rs2_used,
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_flush,
    input  logic                 i_mem_hold,
    output state_e               o_action,
    output logic                 o_pc_write,
    output logic                 o_if_id_write,
    output logic                 o_if_id_flush
);

    logic w_load_use;

    // A load to x0 never produces a value worth waiting for.
    assign w_load_use = i_ex_mem_read && (i_ex_rd != BUBBLE_REG) &&
                        (src_hits(i_rs1_used, i_rs1, i_ex_rd) ||
                         src_hits(i_rs2_used, i_rs2, i_ex_rd));

    always_comb begin
        o_action      = ST_RUN;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b0;

        if (i_ex_flush) begin
            // Redirect wins: fetch continues from the new target, IF/ID is squashed.
            o_action      = ST_FLUSH;
            o_if_id_flush = 1'b1;
        end else if (i_mem_hold) begin
            // Whole front end freezes; a pending load-use is simply re-evaluated later.
            o_action      = ST_HOLD;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end else if (w_load_use) begin
            o_action      = ST_STALL;
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
        end

        // While in reset the front end sees a plain "run" regardless of hazards.
        if (i_rst) begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_if_id_flush = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, memory hold and branch flush control plus event counters.
// Latency: one cycle ID -> ID_EX; stall/hold/flush enables are combinational in the same cycle.
// Backpressure: MEM_hold freezes PC, IF/ID and ID/EX; load-use freezes PC and IF/ID for one cycle.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   ID_*                            decoded instruction in ID (indices, uses, controls, PC, operands, imm)
//   EX_flush, MEM_hold              redirect from EX, downstream memory not ready
//   ID_EX_*                         registered ID/EX contents (rs1/rs2/rd also feed forwarding)
//   PC_Write, IF_ID_Write, IF_ID_Flush  front-end controls
//   state, stall_count, flush_count debug FSM state and saturating event counters
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_rs1_used,
    input  logic             ID_rs2_used,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_MemToReg,
    input  logic             ID_ALUSrc,
    input  logic             ID_Branch,
    input  logic [3:0]       ID_ALUOp,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_rdata1,
    input  logic [XLEN-1:0]  ID_rdata2,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic             EX_flush,
    input  logic             MEM_hold,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ID_EX_MemWrite,
    output logic             ID_EX_MemToReg,
    output logic             ID_EX_ALUSrc,
    output logic             ID_EX_Branch,
    output logic [3:0]       ID_EX_ALUOp,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [XLEN-1:0]  ID_EX_rdata1,
    output logic [XLEN-1:0]  ID_EX_rdata2,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t                w_id_ctrl;
    state_e               w_action;
    state_e               w_next_state;

    state_e               r_state;
    ctrl_t                r_ctrl;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [4:0]           r_rd;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_rdata1;
    logic [XLEN-1:0]      r_rdata2;
    logic [XLEN-1:0]      r_imm;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;

    assign w_id_ctrl = '{reg_write:  ID_RegWrite,
                         mem_read:   ID_MemRead,
                         mem_write:  ID_MemWrite,
                         mem_to_reg: ID_MemToReg,
                         alu_src:    ID_ALUSrc,
                         branch:     ID_Branch,
                         alu_op:     ID_ALUOp};

    // Hazard check looks at what is already in ID/EX, so a bubble inserted by a
    // stall clears mem_read and the same instruction proceeds on the next edge.
    id_ex_stage_hazard_detect u_hazard (
        .i_rst         (rst),
        .i_rs1         (ID_rs1),
        .i_rs2         (ID_rs2),
        .i_rs1_used    (ID_rs1_used),
        .i_rs2_used    (ID_rs2_used),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_ex_flush    (EX_flush),
        .i_mem_hold    (MEM_hold),
        .o_action      (w_action),
        .o_pc_write    (PC_Write),
        .o_if_id_write (IF_ID_Write),
        .o_if_id_flush (IF_ID_Flush)
    );

    // FSM: the state simply records which action was applied at the last edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_RUN;
        case (w_action)
            ST_FLUSH: w_next_state = ST_FLUSH;
            ST_HOLD:  w_next_state = ST_HOLD;
            ST_STALL: w_next_state = ST_STALL;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // ID/EX register: load on run, keep on hold, bubble on stall or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= CTRL_BUBBLE;
            r_rs1    <= BUBBLE_REG;
            r_rs2    <= BUBBLE_REG;
            r_rd     <= BUBBLE_REG;
            r_pc     <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_imm    <= '0;
        end else begin
            case (w_next_state)
                ST_RUN: begin
                    r_ctrl   <= w_id_ctrl;
                    r_rs1    <= ID_rs1;
                    r_rs2    <= ID_rs2;
                    r_rd     <= ID_rd;
                    r_pc     <= ID_pc;
                    r_rdata1 <= ID_rdata1;
                    r_rdata2 <= ID_rdata2;
                    r_imm    <= ID_imm;
                end
                ST_HOLD: begin
                    r_ctrl   <= r_ctrl;
                    r_rs1    <= r_rs1;
                    r_rs2    <= r_rs2;
                    r_rd     <= r_rd;
                    r_pc     <= r_pc;
                    r_rdata1 <= r_rdata1;
                    r_rdata2 <= r_rdata2;
                    r_imm    <= r_imm;
                end
                default: begin
                    // Zero the don't-care fields too so a bubble is fully deterministic.
                    r_ctrl   <= CTRL_BUBBLE;
                    r_rs1    <= BUBBLE_REG;
                    r_rs2    <= BUBBLE_REG;
                    r_rd     <= BUBBLE_REG;
                    r_pc     <= '0;
                    r_rdata1 <= '0;
                    r_rdata2 <= '0;
                    r_imm    <= '0;
                end
            endcase
        end
    end

    // Saturating event counters; hold cycles count as neither stall nor flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_next_state == ST_STALL) && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((w_next_state == ST_FLUSH) && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ID_EX_rs1      = r_rs1;
    assign ID_EX_rs2      = r_rs2;
    assign ID_EX_rd       = r_rd;
    assign ID_EX_RegWrite = r_ctrl.reg_write;
    assign ID_EX_MemRead  = r_ctrl.mem_read;
    assign ID_EX_MemWrite = r_ctrl.mem_write;
    assign ID_EX_MemToReg = r_ctrl.mem_to_reg;
    assign ID_EX_ALUSrc   = r_ctrl.alu_src;
    assign ID_EX_Branch   = r_ctrl.branch;
    assign ID_EX_ALUOp    = r_ctrl.alu_op;
    assign ID_EX_pc       = r_pc;
    assign ID_EX_rdata1   = r_rdata1;
    assign ID_EX_rdata2   = r_rdata2;
    assign ID_EX_imm      = r_imm;
    assign state          = r_state;
    assign stall_count    = r_stall_cnt;
    assign flush_count    = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        branch;
        logic [3:0]  aluop;
    } ie_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ie_t  id_in = '0;
    logic rs1u = 1'b0;
    logic rs2u = 1'b0;
    logic EX_flush = 1'b0;
    logic MEM_hold = 1'b0;

    logic [4:0]       ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
    logic             ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Branch;
    logic [3:0]       ID_EX_ALUOp;
    logic [XLEN-1:0]  ID_EX_pc, ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
    logic             PC_Write, IF_ID_Write, IF_ID_Flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(id_in.rs1), .ID_rs2(id_in.rs2), .ID_rd(id_in.rd),
        .ID_rs1_used(rs1u), .ID_rs2_used(rs2u),
        .ID_RegWrite(id_in.regwrite), .ID_MemRead(id_in.memread),
        .ID_MemWrite(id_in.memwrite), .ID_MemToReg(id_in.memtoreg),
        .ID_ALUSrc(id_in.alusrc), .ID_Branch(id_in.branch), .ID_ALUOp(id_in.aluop),
        .ID_pc(id_in.pc), .ID_rdata1(id_in.rdata1), .ID_rdata2(id_in.rdata2), .ID_imm(id_in.imm),
        .EX_flush(EX_flush), .MEM_hold(MEM_hold),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
        .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUOp(ID_EX_ALUOp),
        .ID_EX_pc(ID_EX_pc), .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2),
        .ID_EX_imm(ID_EX_imm),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    ie_t dut_ie;
    assign dut_ie = '{pc: ID_EX_pc, rdata1: ID_EX_rdata1, rdata2: ID_EX_rdata2, imm: ID_EX_imm,
                      rs1: ID_EX_rs1, rs2: ID_EX_rs2, rd: ID_EX_rd,
                      regwrite: ID_EX_RegWrite, memread: ID_EX_MemRead, memwrite: ID_EX_MemWrite,
                      memtoreg: ID_EX_MemToReg, alusrc: ID_EX_ALUSrc, branch: ID_EX_Branch,
                      aluop: ID_EX_ALUOp};

    // ---------------- behavioural model ----------------
    ie_t m_ie;
    int  m_state;
    int  m_stall;
    int  m_flush;

    // 0 run, 1 stall, 2 hold, 3 flush for the coming edge.
    function automatic int decide();
        bit lu;
        lu = m_ie.memread && (m_ie.rd != 0) &&
             ((rs1u && id_in.rs1 == m_ie.rd) || (rs2u && id_in.rs2 == m_ie.rd));
        if (EX_flush)      return 3;
        else if (MEM_hold) return 2;
        else if (lu)       return 1;
        else               return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ie    <= '0;
            m_state <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_state <= decide();
            case (decide())
                0:       m_ie <= id_in;
                2:       m_ie <= m_ie;
                default: m_ie <= '0;
            endcase
            if (decide() == 1) m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (decide() == 3) m_flush <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int a;
        logic [2:0] exp_ctl;
        a = decide();
        if (rst)         exp_ctl = 3'b110;
        else if (a == 3) exp_ctl = 3'b111;
        else if (a == 0) exp_ctl = 3'b110;
        else             exp_ctl = 3'b000;
        chk("m_front_ctl", {61'd0, PC_Write, IF_ID_Write, IF_ID_Flush}, {61'd0, exp_ctl});
        chk("m_state", {62'd0, state}, 64'(m_state));
        chk("m_stall_count", {60'd0, stall_count}, 64'(m_stall));
        chk("m_flush_count", {60'd0, flush_count}, 64'(m_flush));
        checks++;
        if (dut_ie !== m_ie) begin
            errors++;
            $display("FAIL m_id_ex: got 0x%0h expected 0x%0h at %0t", dut_ie, m_ie, $time);
        end
    end

    function automatic ie_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ld, input logic [3:0] aluop);
        ie_t v;
        v          = '0;
        v.pc       = pc;
        v.rdata1   = pc ^ 32'hA5A5_0000;
        v.rdata2   = pc + 32'd7;
        v.imm      = pc >> 2;
        v.rs1      = rs1;
        v.rs2      = rs2;
        v.rd       = rd;
        v.regwrite = 1'b1;
        v.memread  = ld;
        v.memtoreg = ld;
        v.alusrc   = ld;
        v.aluop    = aluop;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with hazards requested: front end must still read "run".
        EX_flush = 1'b1;
        MEM_hold = 1'b1;
        tick();
        chk("rst_pc_write", {63'd0, PC_Write}, 64'd1);
        chk("rst_ifid_write", {63'd0, IF_ID_Write}, 64'd1);
        chk("rst_ifid_flush", {63'd0, IF_ID_Flush}, 64'd0);
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_stall_count", {60'd0, stall_count}, 64'd0);
        chk("rst_id_ex_rd", {59'd0, ID_EX_rd}, 64'd0);
        EX_flush = 1'b0;
        MEM_hold = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        tick();

        // lw x5 then add using x5 -> one stall
        id_in = mk(32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        tick();
        chk("lw_loaded_rd", {59'd0, ID_EX_rd}, 64'd5);
        id_in = mk(32'h104, 5'd5, 5'd7, 5'd6, 1'b0, 4'd2); rs1u = 1'b1; rs2u = 1'b1;
        #1;
        chk("lu_pc_write", {63'd0, PC_Write}, 64'd0);
        chk("lu_ifid_write", {63'd0, IF_ID_Write}, 64'd0);
        tick();
        chk("stall_regwrite", {63'd0, ID_EX_RegWrite}, 64'd0);
        chk("stall_rd", {59'd0, ID_EX_rd}, 64'd0);
        chk("stall_state", {62'd0, state}, 64'd1);
        chk("stall_count_1", {60'd0, stall_count}, 64'd1);
        tick();
        chk("after_stall_rd", {59'd0, ID_EX_rd}, 64'd6);
        chk("after_stall_state", {62'd0, state}, 64'd0);

        // rs1 matches but is not used -> no stall
        id_in = mk(32'h108, 5'd2, 5'd0, 5'd5, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        tick();
        id_in = mk(32'h10c, 5'd5, 5'd7, 5'd6, 1'b0, 4'd2); rs1u = 1'b0; rs2u = 1'b1;
        #1 chk("unused_pc_write", {63'd0, PC_Write}, 64'd1);
        tick();
        chk("unused_pc", 64'(ID_EX_pc), 64'h10c);
        chk("unused_state", {62'd0, state}, 64'd0);
        chk("unused_stall_count", {60'd0, stall_count}, 64'd1);

        // load to x0, consumer reads x0 -> no stall
        id_in = mk(32'h110, 5'd1, 5'd0, 5'd0, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        tick();
        id_in = mk(32'h114, 5'd0, 5'd0, 5'd3, 1'b0, 4'd2); rs1u = 1'b1; rs2u = 1'b1;
        #1 chk("x0_pc_write", {63'd0, PC_Write}, 64'd1);
        tick();
        chk("x0_rd", {59'd0, ID_EX_rd}, 64'd3);

        // flush beats hold and load-use
        id_in = mk(32'h118, 5'd2, 5'd0, 5'd5, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        tick();
        id_in = mk(32'h11c, 5'd5, 5'd5, 5'd6, 1'b0, 4'd2); rs1u = 1'b1; rs2u = 1'b1;
        EX_flush = 1'b1; MEM_hold = 1'b1;
        #1;
        chk("flush_ifid_flush", {63'd0, IF_ID_Flush}, 64'd1);
        chk("flush_pc_write", {63'd0, PC_Write}, 64'd1);
        tick();
        EX_flush = 1'b0; MEM_hold = 1'b0;
        chk("flush_state", {62'd0, state}, 64'd3);
        chk("flush_count_1", {60'd0, flush_count}, 64'd1);
        chk("flush_stall_same", {60'd0, stall_count}, 64'd1);
        chk("flush_bubble_rd", {59'd0, ID_EX_rd}, 64'd0);
        chk("flush_bubble_memread", {63'd0, ID_EX_MemRead}, 64'd0);

        // hold three cycles with a masked load-use pending
        id_in = mk(32'h200, 5'd2, 5'd0, 5'd5, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        tick();
        id_in = mk(32'h204, 5'd5, 5'd0, 5'd6, 1'b0, 4'd2); rs1u = 1'b1; rs2u = 1'b0;
        MEM_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_pc_write", {63'd0, PC_Write}, 64'd0);
            tick();
            chk("hold_pc", 64'(ID_EX_pc), 64'h200);
            chk("hold_rd", {59'd0, ID_EX_rd}, 64'd5);
            chk("hold_state", {62'd0, state}, 64'd2);
            chk("hold_stall_count", {60'd0, stall_count}, 64'd1);
            chk("hold_flush_count", {60'd0, flush_count}, 64'd1);
            id_in.imm = id_in.imm + 32'd1;
        end
        MEM_hold = 1'b0;
        #1 chk("post_hold_lu", {63'd0, PC_Write}, 64'd0);
        tick();
        chk("post_hold_state", {62'd0, state}, 64'd1);
        chk("post_hold_stall", {60'd0, stall_count}, 64'd2);
        tick();
        chk("post_hold_add_rd", {59'd0, ID_EX_rd}, 64'd6);

        // back-to-back dependent loads until the stall counter saturates
        id_in = mk(32'h300, 5'd5, 5'd0, 5'd5, 1'b1, 4'd0); rs1u = 1'b1; rs2u = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i == 2)  chk("b2b_stall_3", {60'd0, stall_count}, 64'd3);
            if (i == 3)  chk("b2b_single_stall", {62'd0, state}, 64'd0);
            if (i == 26) chk("sat_reach_15", {60'd0, stall_count}, 64'd15);
            if (i == 34) chk("sat_hold_15", {60'd0, stall_count}, 64'd15);
            if (i == 34) chk("sat_in_stall", {62'd0, state}, 64'd1);
        end

        // reset in the middle of a stall
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_state", {62'd0, state}, 64'd0);
        chk("mid_rst_stall", {60'd0, stall_count}, 64'd0);
        chk("mid_rst_flush", {60'd0, flush_count}, 64'd0);
        chk("mid_rst_pc", 64'(ID_EX_pc), 64'd0);
        chk("mid_rst_memread", {63'd0, ID_EX_MemRead}, 64'd0);
        chk("mid_rst_pc_write", {63'd0, PC_Write}, 64'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_normal_pc", 64'(ID_EX_pc), 64'h300);
        chk("post_rst_normal_state", {62'd0, state}, 64'd0);

        // reset in the middle of a hold
        MEM_hold = 1'b1;
        tick();
        chk("hold2_state", {62'd0, state}, 64'd2);
        #1 rst = 1'b1;
        #1;
        chk("hold_rst_rd", {59'd0, ID_EX_rd}, 64'd0);
        chk("hold_rst_ifid_write", {63'd0, IF_ID_Write}, 64'd1);
        MEM_hold = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
